rv_mem_resp: RTL and testbench

// - Memory-side responder to the multicycle RISC-V core's memory interface.
// - Serves imem fetches and dmem load/store; sits beside rv_top in the system top.
// - Built-in byte-serial boot loader fills imem while the core is held in reset,

---
 rtl/rv_mem_resp.sv | 137 +++++++++++++
 tb/tb_rv_mem_resp.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mem_resp.sv
// Memory responder for the multicycle RISC-V core: imem/dmem plus byte-serial boot loader (optional RV_MEM_STORE_CNT_EN store counter).
// Latency: reads are combinational (zero cycle); stores and imem fills commit on the rising edge.
// Backpressure: loader bytes move on ld_valid & ld_ready; ld_ready drops for good once RUN is reached.
module rv_mem_resp #(
    parameter int DPWIDTH    = 32,
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DPWIDTH-1:0] imem_addr,
    output logic [DPWIDTH-1:0] imem_rdata,
    input  logic [DPWIDTH-1:0] dmem_addr,
    input  logic [DPWIDTH-1:0] dmem_wdata,
    input  logic               memrw,
    output logic [DPWIDTH-1:0] dmem_rdata,
    input  logic               ld_valid,
    input  logic [7:0]         ld_byte,
    output logic               ld_ready,
    output logic               core_rst,
    output logic               addr_err,
    output logic [15:0]        st_cnt
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);
    localparam logic [16:0] IMEM_LIM = 17'(IMEM_WORDS);

    typedef enum logic [1:0] {HDR0, HDR1, DATA, RUN} state_t;

    state_t             state;
    logic [15:0]        nwords;
    logic [15:0]        widx;
    logic [1:0]         bcnt;
    logic [23:0]        wbuf;
    logic [DPWIDTH-1:0] imem [IMEM_WORDS];
    logic [DPWIDTH-1:0] dmem [DMEM_WORDS];

    logic           xfer;
    logic [IAW-1:0] i_idx;
    logic [DAW-1:0] d_idx;
    logic           i_inr, i_al, d_inr, d_al, st_ok, word_done;

    assign xfer      = ld_valid & ld_ready;
    assign i_idx     = imem_addr[IAW+1:2];
    assign d_idx     = dmem_addr[DAW+1:2];
    assign i_inr     = (imem_addr[DPWIDTH-1:IAW+2] == '0);
    assign d_inr     = (dmem_addr[DPWIDTH-1:DAW+2] == '0);
    assign i_al      = (imem_addr[1:0] == 2'b00);
    assign d_al      = (dmem_addr[1:0] == 2'b00);
    assign st_ok     = (state == RUN) && memrw && d_al && d_inr;
    assign word_done = (state == DATA) && xfer && (bcnt == 2'd3);

    assign imem_rdata = i_inr ? imem[i_idx] : '0;
    assign dmem_rdata = d_inr ? dmem[d_idx] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= HDR0;
            ld_ready <= 1'b0;
            core_rst <= 1'b0;
            nwords   <= '0;
            widx     <= '0;
            bcnt     <= '0;
            wbuf     <= '0;
        end else begin
            case (state)
                HDR0: begin
                    ld_ready <= 1'b1;
                    if (xfer) begin
                        nwords[7:0] <= ld_byte;
                        state       <= HDR1;
                    end
                end
                HDR1: begin
                    if (xfer) begin
                        nwords[15:8] <= ld_byte;
                        if ({ld_byte, nwords[7:0]} == 16'd0) begin
                            state    <= RUN;
                            ld_ready <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        // Little-endian shift: after three bytes wbuf = {b2, b1, b0}
                        bcnt <= bcnt + 2'd1;
                        wbuf <= {ld_byte, wbuf[23:8]};
                        if (bcnt == 2'd3) begin
                            widx <= widx + 16'd1;
                            if (widx + 16'd1 == nwords) begin
                                state    <= RUN;
                                ld_ready <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    ld_ready <= 1'b0;
                    core_rst <= 1'b1;
                end
            endcase
        end
    end

    // Words past the end of imem are consumed by the loader but never written.
    always_ff @(posedge clk) begin
        if (word_done && ({1'b0, widx} < IMEM_LIM)) begin
            imem[widx[IAW-1:0]] <= {ld_byte, wbuf};
        end
        if (st_ok) begin
            dmem[d_idx] <= dmem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_err <= 1'b0;
        end else if ((state == RUN) && (!i_al || !i_inr || (memrw && (!d_al || !d_inr)))) begin
            addr_err <= 1'b1;
        end
    end

`ifdef RV_MEM_STORE_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_cnt <= '0;
        end else if (st_ok && (st_cnt != 16'hFFFF)) begin
            st_cnt <= st_cnt + 16'd1;
        end
    end
`else
    assign st_cnt = '0;
`endif

endmodule

// File: tb/tb_rv_mem_resp.sv
// Scoreboard bench for rv_mem_resp: stimulus queues expected outputs, a negedge monitor compares.
module tb_rv_mem_resp;
    localparam int IW = 16;
    localparam int DW = 16;
    localparam int K_IRD = 0, K_DRD = 1, K_ERR = 2, K_CNT = 3, K_CRST = 4, K_RDY = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_addr = '0, dmem_addr = '0, dmem_wdata = '0;
    logic [31:0] imem_rdata, dmem_rdata;
    logic        memrw = 1'b0, ld_valid = 1'b0;
    logic [7:0]  ld_byte = '0;
    logic        ld_ready, core_rst, addr_err;
    logic [15:0] st_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;
    exp_t sbq[$];

    // Reference model: plain word arrays with "known" flags (memories are not reset)
    logic [31:0] m_imem [IW];
    bit          m_iv   [IW];
    logic [31:0] m_dmem [DW];
    bit          m_dv   [DW];
    int          m_cnt = 0;
    bit          m_err = 1'b0;
    logic [7:0]  img[$];

    rv_mem_resp #(.DPWIDTH(32), .IMEM_WORDS(IW), .DMEM_WORDS(DW)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .memrw(memrw), .dmem_rdata(dmem_rdata),
        .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_ready(ld_ready),
        .core_rst(core_rst), .addr_err(addr_err), .st_cnt(st_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] probe(input int k);
        case (k)
            K_IRD:   return imem_rdata;
            K_DRD:   return dmem_rdata;
            K_ERR:   return {31'b0, addr_err};
            K_CNT:   return {16'b0, st_cnt};
            K_CRST:  return {31'b0, core_rst};
            default: return {31'b0, ld_ready};
        endcase
    endfunction

    exp_t        mon_t;
    logic [31:0] mon_a;
    always @(negedge clk) begin
        while (sbq.size() > 0) begin
            mon_t = sbq.pop_front();
            mon_a = probe(mon_t.kind);
            checks++;
            if (mon_a !== mon_t.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h at %0t", mon_t.name, mon_a, mon_t.exp, $time);
            end
        end
    end

    task automatic expect_out(input int kind, input logic [31:0] e, input string nm);
        exp_t t;
        t.kind = kind;
        t.exp  = e;
        t.name = nm;
        sbq.push_back(t);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit r, done;
        done = 1'b0;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                ld_valid = 1'b0;
                ld_byte  = 8'($urandom);
                step();
            end
        end
        ld_valid = 1'b1;
        ld_byte  = b;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            r = ld_ready;
            @(posedge clk);
            #1;
            if (r) begin
                done = 1'b1;
                break;
            end
        end
        ld_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL ld_handshake: got ld_ready=0 for 50 cycles, expected a transfer");
        end
    endtask

    // Model the first nw words of img as written into imem (header occupies img[0:1]).
    task automatic commit(input int nw);
        for (int i = 0; i < nw && i < IW; i++) begin
            m_imem[i] = {img[2+4*i+3], img[2+4*i+2], img[2+4*i+1], img[2+4*i]};
            m_iv[i]   = 1'b1;
        end
    endtask

    task automatic do_reset();
        memrw     = 1'b0;
        ld_valid  = 1'b0;
        imem_addr = '0;
        dmem_addr = '0;
        rst       = 1'b0;
        step();
        expect_out(K_RDY,  32'd0, "reset_ld_ready");
        expect_out(K_CRST, 32'd0, "reset_core_rst");
        expect_out(K_ERR,  32'd0, "reset_addr_err");
        expect_out(K_CNT,  32'd0, "reset_st_cnt");
        step();
        rst   = 1'b1;
        m_cnt = 0;
        m_err = 1'b0;
    endtask

    task automatic do_load(input bit gaps);
        foreach (img[k]) send_byte(img[k], gaps);
        expect_out(K_CRST, 32'd0, "core_rst_at_last_byte");
        expect_out(K_RDY,  32'd0, "ld_ready_in_run");
        step();
        expect_out(K_CRST, 32'd1, "core_rst_after_load");
        expect_out(K_RDY,  32'd0, "ld_ready_stays_low");
        step();
    endtask

    task automatic cycle(input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] wd, input bit we);
        int ii, di;
        bit iok, dok;
        imem_addr  = ia;
        dmem_addr  = da;
        dmem_wdata = wd;
        memrw      = we;
        ii = int'(ia >> 2);
        di = int'(da >> 2);
        if (ii < IW) begin
            if (m_iv[ii]) expect_out(K_IRD, m_imem[ii], "imem_rdata");
        end else begin
            expect_out(K_IRD, 32'd0, "imem_rdata_oor");
        end
        if (di < DW) begin
            if (m_dv[di]) expect_out(K_DRD, m_dmem[di], "dmem_rdata");
        end else begin
            expect_out(K_DRD, 32'd0, "dmem_rdata_oor");
        end
        expect_out(K_ERR, {31'b0, m_err}, "addr_err");
        expect_out(K_CNT, m_cnt, "st_cnt");
        iok = (ia % 4 == 0) && (ii < IW);
        dok = (da % 4 == 0) && (di < DW);
        if (!iok || (we && !dok)) m_err = 1'b1;
        if (we && dok) begin
            m_dmem[di] = wd;
            m_dv[di]   = 1'b1;
`ifdef RV_MEM_STORE_CNT_EN
            if (m_cnt < 65535) m_cnt++;
`endif
        end
        step();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Fixed two-word boot image, back-to-back bytes
        do_reset();
        img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        do_load(1'b0);
        commit(2);
        imem_addr = 32'h0;
        expect_out(K_IRD, 32'h00000013, "imem0_fixed");
        step();
        imem_addr = 32'h4;
        expect_out(K_IRD, 32'h00100093, "imem1_fixed");
        step();

        // Read-during-write on dmem 0x8
        cycle(32'h0, 32'h8, 32'h11111111, 1'b1);
        cycle(32'h0, 32'h8, 32'hDEADBEEF, 1'b1);
        expect_out(K_DRD, 32'hDEADBEEF, "dmem8_after_store");
        cycle(32'h0, 32'h8, 32'h0, 1'b0);

        // Misaligned and out-of-range stores are suppressed and set a sticky error
        cycle(32'h0, 32'h4, 32'h22222222, 1'b1);
        cycle(32'h0, 32'h0, 32'h33333333, 1'b1);
        cycle(32'h0, 32'h6, 32'hBAD00006, 1'b1);
        cycle(32'h0, 32'(4*DW), 32'hBAD00040, 1'b1);
        cycle(32'h0, 32'h4, 32'h0, 1'b0);
        cycle(32'h0, 32'h0, 32'h0, 1'b0);
        cycle(32'h0, 32'h8, 32'h0, 1'b0);

        // Reset mid-load of N=3 after 6 data bytes, then empty header
        do_reset();
        img.delete();
        img.push_back(8'h03);
        img.push_back(8'h00);
        for (int k = 0; k < 12; k++) img.push_back(8'($urandom));
        for (int k = 0; k < 8; k++) send_byte(img[k], 1'b0);
        commit(1);
        do_reset();
        img = '{8'h00, 8'h00};
        do_load(1'b1);
        imem_addr = 32'h4;
        expect_out(K_IRD, 32'h00100093, "imem1_kept_after_abort");
        step();
        cycle(32'h0, 32'h8, 32'h0, 1'b0);

        // Oversized random image with random valid gaps: excess words discarded, no wrap
        do_reset();
        n = IW + 2;
        img.delete();
        img.push_back(8'(n));
        img.push_back(8'(n >> 8));
        for (int k = 0; k < 4*n; k++) img.push_back(8'($urandom));
        do_load(1'b1);
        commit(n);

        for (int k = 0; k < 150; k++) begin
            cycle(32'(4*$urandom_range(0, IW-1)), 32'(4*$urandom_range(0, DW-1)),
                  $urandom, 1'($urandom_range(0, 1)));
        end

        // Fetch-side errors: misaligned, then out of range
        cycle(32'h2, 32'h0, 32'h0, 1'b0);
        cycle(32'(4*IW), 32'h0, 32'h0, 1'b0);
        cycle(32'h0, 32'h0, 32'h0, 1'b0);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
